// File: rtl/char_grid_scheduler.sv
// char_grid_scheduler: walks the text screen cell by cell, fetches the text
// entry and glyph for each cell, and hands the staged cell to the font shape
// renderer with a one-cycle fontReady pulse. The next cell is prefetched
// while the renderer is busy, so the committed outputs must stay frozen
// until the next commit edge.

package char_grid_pkg;
    typedef logic [19:0] SramAddress_t;

    typedef struct packed {
        logic [127:0] shape;
        logic [8:0]   fg;
        logic [8:0]   bg;
    } CharGrid_t;

    typedef struct packed {
        logic bright;
        logic negative;
        logic underline;
        logic blink;
    } CharEffect_t;
endpackage

module char_grid_scheduler
    import char_grid_pkg::*;
#(
    parameter int COLUMNS      = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [11:0]   textAddr,
    input  logic [31:0]   textData,
    output logic [7:0]    fontAddr,
    input  logic [127:0]  fontData,
    output CharGrid_t     grid,
    output CharEffect_t   effect,
    output SramAddress_t  baseAddress,
    output logic          currentCursor,
    output logic          blinkStatus,
    output logic          fontReady,
    input  logic          done,
    input  logic          cursorEnable,
    input  logic [4:0]    cursorRow,
    input  logic [6:0]    cursorCol,
    output logic          frameDone
);

    // Framebuffer words per character row, and per character column
    // (two pixels per word).
    localparam int ROW_STRIDE = COLUMNS * CHAR_W * CHAR_H / 2;
    localparam int COL_STRIDE = CHAR_W / 2;
    localparam int FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [2:0] {
        FETCH_TEXT  = 3'd0,
        FETCH_FONT  = 3'd1,
        LATCH_SHAPE = 3'd2,
        STAGED      = 3'd3,
        HANDOFF     = 3'd4,
        HOLD        = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           row_q, row_d;
    logic [6:0]           col_q, col_d;
    CharGrid_t            stg_grid_q, stg_grid_d;
    CharEffect_t          stg_effect_q, stg_effect_d;
    logic [7:0]           stg_code_q, stg_code_d;
    CharGrid_t            grid_q, grid_d;
    CharEffect_t          effect_q, effect_d;
    SramAddress_t         base_q, base_d;
    logic                 cursor_q, cursor_d;
    logic                 blink_q, blink_d;
    logic                 font_ready_q, font_ready_d;
    logic                 frame_done_q, frame_done_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [11:0]          text_addr_s;
    SramAddress_t         commit_base_s;
    logic                 cursor_hit_s;
    logic                 last_col_s;
    logic                 last_row_s;
    logic                 unused_s;

    // The row/col counters never leave the screen, so an off-screen cursor
    // position simply cannot compare equal.
    assign text_addr_s   = (12'(row_q) * 12'(COLUMNS)) + 12'(col_q);
    assign commit_base_s = (20'(row_q) * 20'(ROW_STRIDE)) + (20'(col_q) * 20'(COL_STRIDE));
    assign cursor_hit_s  = cursorEnable && (cursorRow == row_q) && (cursorCol == col_q);
    assign last_col_s    = (col_q == 7'(COLUMNS - 1));
    assign last_row_s    = (row_q == 5'(ROWS - 1));
    assign unused_s      = ^textData[31:30];

    // RAM/ROM addresses; the font address follows the RAM output directly
    // while that output is valid, otherwise it holds the staged code.
    assign textAddr      = text_addr_s;
    assign fontAddr      = (state_q == FETCH_FONT) ? textData[7:0] : stg_code_q;

    assign grid          = grid_q;
    assign effect        = effect_q;
    assign baseAddress   = base_q;
    assign currentCursor = cursor_q;
    assign blinkStatus   = blink_q;
    assign fontReady     = font_ready_q;
    assign frameDone     = frame_done_q;

    // Next-state logic: fetch pipeline, commit, cell advance and blink timing.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        stg_grid_d   = stg_grid_q;
        stg_effect_d = stg_effect_q;
        stg_code_d   = stg_code_q;
        grid_d       = grid_q;
        effect_d     = effect_q;
        base_d       = base_q;
        cursor_d     = cursor_q;
        blink_d      = blink_q;
        font_ready_d = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            FETCH_TEXT: begin
                state_d = FETCH_FONT;
            end
            FETCH_FONT: begin
                stg_code_d    = textData[7:0];
                stg_grid_d.fg = textData[16:8];
                stg_grid_d.bg = textData[25:17];
                stg_effect_d  = CharEffect_t'(textData[29:26]);
                state_d       = LATCH_SHAPE;
            end
            LATCH_SHAPE: begin
                stg_grid_d.shape = fontData;
                state_d          = STAGED;
            end
            STAGED: begin
                if (done && enable) begin
                    grid_d       = stg_grid_q;
                    effect_d     = stg_effect_q;
                    base_d       = commit_base_s;
                    cursor_d     = cursor_hit_s;
                    font_ready_d = 1'b1;
                    state_d      = HANDOFF;
                end else begin
                    state_d = STAGED;
                end
            end
            HANDOFF: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (last_col_s) begin
                    col_d = 7'd0;
                    if (last_row_s) begin
                        row_d        = 5'd0;
                        frame_done_d = 1'b1;
                        if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            blink_d     = ~blink_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                        end
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
                state_d = FETCH_TEXT;
            end
            default: begin
                state_d = FETCH_TEXT;
            end
        endcase
    end

    // State register with synchronous reset that wins at any edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_TEXT;
            row_q        <= 5'd0;
            col_q        <= 7'd0;
            stg_grid_q   <= '0;
            stg_effect_q <= '0;
            stg_code_q   <= 8'd0;
            grid_q       <= '0;
            effect_q     <= '0;
            base_q       <= '0;
            cursor_q     <= 1'b0;
            blink_q      <= 1'b0;
            font_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            stg_grid_q   <= stg_grid_d;
            stg_effect_q <= stg_effect_d;
            stg_code_q   <= stg_code_d;
            grid_q       <= grid_d;
            effect_q     <= effect_d;
            base_q       <= base_d;
            cursor_q     <= cursor_d;
            blink_q      <= blink_d;
            font_ready_q <= font_ready_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: doc/char_grid_scheduler.md
CHAR_GRID_SCHEDULER -- requirements
Module: char_grid_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- COLUMNS, 80, character columns per screen.
- ROWS, 30, character rows per screen.
- CHAR_W, 8, pixels per character row.
- CHAR_H, 16, pixel rows per character.
- BLINK_FRAMES, 32, full frames per blinkStatus toggle.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits handoffs to the renderer.
- textAddr  out  12  text RAM address = row*COLUMNS+col.
- textData  in  32  text entry: [7:0] code, [16:8] fg, [25:17] bg, [29:26] {bright,negative,underline,blink}, [31:30] ignored.
- fontAddr  out  8  font ROM address (character code).
- fontData  in  128  glyph shape, bit 127 = top-left pixel.
- grid  out  CharGrid_t  shape, foreground, background of the committed cell.
- effect  out  CharEffect_t  effect bits of the committed cell.
- baseAddress  out  SramAddress_t (20)  framebuffer word address of the committed cell's top-left pixel pair.
- currentCursor  out  1  committed cell is the cursor cell.
- blinkStatus  out  1  blink phase.
- fontReady  out  1  one-cycle start pulse to the font shape renderer.
- done  in  1  renderer idle (in its done state).
- cursorEnable  in  1  cursor display enable.
- cursorRow  in  5  cursor row.
- cursorCol  in  7  cursor column.
- frameDone  out  1  one-cycle pulse when the last cell of a frame advances.

Function
REQ-003 Text RAM and font ROM have 1-cycle synchronous read latency; textAddr and fontAddr are combinational from internal state.
REQ-004 States: FETCH_TEXT, FETCH_FONT, LATCH_SHAPE, STAGED, HANDOFF, HOLD.
REQ-005 FETCH_TEXT: drive textAddr from (row,col); 1 cycle; then go to FETCH_FONT.
REQ-006 FETCH_FONT: capture textData into staging attributes; fontAddr = textData[7:0]; go to LATCH_SHAPE.
REQ-007 LATCH_SHAPE: capture fontData into staging shape; go to STAGED.
REQ-008 STAGED: remain while !(done && enable); on the edge where done && enable is true, commit in a single edge:
- grid, effect <= staging;
- baseAddress <= row*(COLUMNS*CHAR_W*CHAR_H/2) + col*(CHAR_W/2);
- currentCursor <= cursorEnable && row==cursorRow && col==cursorCol;
- fontReady <= 1;
- next state HANDOFF.
REQ-009 HANDOFF: fontReady high for exactly this cycle; fontReady <= 0; go to HOLD.
REQ-010 HOLD: advance the cell; go to FETCH_TEXT.
- col+1; on col==COLUMNS-1, col=0 and row+1.
- On row==ROWS-1 && col==COLUMNS-1, wrap to (0,0) and pulse frameDone.
REQ-011 grid, effect, baseAddress and currentCursor change only on a commit edge. They stay stable while the renderer renders, because the renderer uses effect and currentCursor unlatched.
REQ-012 Prefetch of the next cell (FETCH_TEXT through LATCH_SHAPE) overlaps rendering. Minimum handoff-to-handoff spacing is 6 cycles.
REQ-013 Frame counter counts frameDone pulses modulo BLINK_FRAMES; blinkStatus toggles when it wraps to 0.
REQ-014 Cursor inputs are sampled only at the commit edge. A cursor row or column outside the screen never matches.
REQ-015 enable low blocks only the commit; fetches continue up to STAGED.
REQ-016 Address arithmetic is unsigned, 20 bits. Maximum address 29*5120+79*4 = 148796; no overflow.

Reset
REQ-017 rst high at any clock edge, including mid-handoff:
- state=FETCH_TEXT, row=col=0;
- fontReady=0, frameDone=0, blinkStatus=0, currentCursor=0;
- grid, effect, baseAddress = 0;
- frame counter = 0, staging = 0.
REQ-018 The first handoff after reset occurs no earlier than 4 cycles after rst deasserts, and only once done=1.

Verification
REQ-019 Reset then done=1, enable=1, cell (0,0) = code 0x41, fg 0x1FF, bg 0 -> fontAddr=0x41 in FETCH_FONT; fontReady pulses at cycle 4 with baseAddress=0; grid.shape = ROM[0x41].
REQ-020 Commit of cell (1,2) -> baseAddress=5128; textAddr was 82.
REQ-021 Hold done=0 for 100 cycles after staging -> fontReady stays 0; grid, effect and baseAddress stay unchanged; fontReady pulses one cycle after done rises.
REQ-022 Cursor (3,5) with cursorEnable=1 -> currentCursor=1 only for cell (3,5); with cursorEnable=0 it is never 1.
REQ-023 Run 2400 handoffs -> frameDone pulses once after cell (29,79); next textAddr=0; blinkStatus toggles after 32 frames.
REQ-024 Assert rst during HANDOFF -> next cycle fontReady=0, textAddr=0; sequence restarts at cell (0,0).
